// File: rtl/noc16_pkg.sv
`default_nettype none
// ============================================================================
// Module      : noc16_pkg
// Description : Shared constants for the NOC16 service-channel responder:
//               command opcodes, response codes, register addresses and the
//               responder FSM state type.
// Revision    : 1.0 - initial release
// ============================================================================
package noc16_pkg;

  // Host command opcodes
  localparam logic [7:0] C_OP_READ       = 8'h01;
  localparam logic [7:0] C_OP_WRITE      = 8'h02;

  // Response codes
  localparam logic [7:0] C_RSP_READ_ACK  = 8'h81;
  localparam logic [7:0] C_RSP_WRITE_ACK = 8'h82;
  localparam logic [7:0] C_RSP_ERROR     = 8'hFF;

  // Register map
  localparam logic [7:0] C_ADDR_SERIAL   = 8'h00;
  localparam logic [7:0] C_ADDR_SWITCHES = 8'h01;
  localparam logic [7:0] C_ADDR_LEDS     = 8'h02;
  localparam logic [7:0] C_ADDR_ABEND    = 8'h03;
  localparam logic [7:0] C_ADDR_WAYPOINT = 8'h04;
  localparam logic [7:0] C_ADDR_SCRATCH  = 8'h05;
  localparam logic [7:0] C_ADDR_STATS    = 8'h06;

  // Responder FSM: one command outstanding at a time
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/noc16_sync2.sv
`default_nettype none
// ============================================================================
// Module      : noc16_sync2
// Description : 8-bit two-flop synchroniser for asynchronous GPIO switches.
//               Both stages clear to zero on reset.
// Ports       : clk   - system clock
//               reset - asynchronous active-high reset
//               d     - asynchronous input
//               q     - synchronised output (2-cycle latency)
// Revision    : 1.0 - initial release
// ============================================================================
module noc16_sync2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] d,
  output logic [7:0] q
);

  logic [7:0] r_meta;
  logic [7:0] r_sync;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_meta <= 8'd0;
      r_sync <= 8'd0;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule
`default_nettype wire

// File: rtl/noc16_reg_responder.sv
`default_nettype none
// ============================================================================
// Module      : noc16_reg_responder
// Description : Device-side responder for the NOC16 service channel. Accepts
//               single-beat READ/WRITE commands on TxData, executes them on a
//               small register file and returns one response beat on RxData.
// Ports       : clk, reset (async, active-high)
//               Ksubs3_Noc16_TxData_* - command channel (lo/cmd/valid in, rdy out)
//               Ksubs3_Noc16_RxData_* - response channel (lo/cmd/valid out, rdy in)
//               ksubsGpioSwitches     - async switch inputs
//               ksubsGpioLeds, ksubsAbendSyndrome, ksubsManualWaypoint - regs
// Config      : NOC16_RESP_STATS_EN - adds read-only STATS register at 0x06
//               holding saturating accepted/error command counters.
// Revision    : 1.0 - initial release
// ============================================================================
module noc16_reg_responder
  import noc16_pkg::*;
#(
  parameter logic [31:0] SERIAL_NUMBER = 32'd1236
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] Ksubs3_Noc16_TxData_lo,
  input  logic [7:0]  Ksubs3_Noc16_TxData_cmd,
  input  logic        Ksubs3_Noc16_TxData_valid,
  output logic        Ksubs3_Noc16_TxData_rdy,
  output logic [63:0] Ksubs3_Noc16_RxData_lo,
  output logic [7:0]  Ksubs3_Noc16_RxData_cmd,
  output logic        Ksubs3_Noc16_RxData_valid,
  input  logic        Ksubs3_Noc16_RxData_rdy,
  input  logic [7:0]  ksubsGpioSwitches,
  output logic [7:0]  ksubsGpioLeds,
  output logic [7:0]  ksubsAbendSyndrome,
  output logic [7:0]  ksubsManualWaypoint
);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  w_switches;
  logic [7:0]  r_leds;
  logic [7:0]  r_abend;
  logic [7:0]  r_waypoint;
  logic [31:0] r_scratch;
  logic [63:0] r_rx_lo;
  logic [7:0]  r_rx_cmd;

  logic        w_accept;
  logic [7:0]  w_addr;
  logic [31:0] w_wdata;
  logic [7:0]  w_rsp_cmd;
  logic [31:0] w_rsp_data;
  logic        w_is_err;
  logic        w_wr_leds;
  logic        w_wr_abend;
  logic        w_wr_waypoint;
  logic        w_wr_scratch;

  // Payload bits [55:32] carry nothing on the command channel.
  logic w_unused;
  assign w_unused = ^Ksubs3_Noc16_TxData_lo[55:32];

  noc16_sync2 u_sync_switches (
    .clk   (clk),
    .reset (reset),
    .d     (ksubsGpioSwitches),
    .q     (w_switches)
  );

`ifdef NOC16_RESP_STATS_EN
  logic [15:0] r_cnt_accept;
  logic [15:0] r_cnt_error;
`endif

  assign w_addr   = Ksubs3_Noc16_TxData_lo[63:56];
  assign w_wdata  = Ksubs3_Noc16_TxData_lo[31:0];
  assign w_accept = Ksubs3_Noc16_TxData_valid && (r_state == ST_IDLE);

  // Command decode: anything not explicitly matched below is an ERROR,
  // which covers unknown opcodes, unmapped addresses and writes to RO regs.
  always_comb begin
    w_rsp_cmd     = C_RSP_ERROR;
    w_rsp_data    = 32'd0;
    w_is_err      = 1'b1;
    w_wr_leds     = 1'b0;
    w_wr_abend    = 1'b0;
    w_wr_waypoint = 1'b0;
    w_wr_scratch  = 1'b0;
    if (Ksubs3_Noc16_TxData_cmd == C_OP_READ) begin
      w_rsp_cmd = C_RSP_READ_ACK;
      w_is_err  = 1'b0;
      case (w_addr)
        C_ADDR_SERIAL:   w_rsp_data = SERIAL_NUMBER;
        C_ADDR_SWITCHES: w_rsp_data = {24'd0, w_switches};
        C_ADDR_LEDS:     w_rsp_data = {24'd0, r_leds};
        C_ADDR_ABEND:    w_rsp_data = {24'd0, r_abend};
        C_ADDR_WAYPOINT: w_rsp_data = {24'd0, r_waypoint};
        C_ADDR_SCRATCH:  w_rsp_data = r_scratch;
`ifdef NOC16_RESP_STATS_EN
        // Counters as they stood before this command is counted.
        C_ADDR_STATS:    w_rsp_data = {r_cnt_accept, r_cnt_error};
`endif
        default: begin
          w_rsp_cmd = C_RSP_ERROR;
          w_is_err  = 1'b1;
        end
      endcase
    end else if (Ksubs3_Noc16_TxData_cmd == C_OP_WRITE) begin
      w_rsp_cmd = C_RSP_WRITE_ACK;
      w_is_err  = 1'b0;
      case (w_addr)
        C_ADDR_LEDS:     w_wr_leds     = 1'b1;
        C_ADDR_ABEND:    w_wr_abend    = 1'b1;
        C_ADDR_WAYPOINT: w_wr_waypoint = 1'b1;
        C_ADDR_SCRATCH:  w_wr_scratch  = 1'b1;
        default: begin
          w_rsp_cmd = C_RSP_ERROR;
          w_is_err  = 1'b1;
        end
      endcase
    end
  end

  // FSM next state and handshake outputs
  always_comb begin
    w_state_nxt               = r_state;
    Ksubs3_Noc16_TxData_rdy   = 1'b0;
    Ksubs3_Noc16_RxData_valid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        Ksubs3_Noc16_TxData_rdy = 1'b1;
        if (Ksubs3_Noc16_TxData_valid) w_state_nxt = ST_RESP;
      end
      ST_RESP: begin
        Ksubs3_Noc16_RxData_valid = 1'b1;
        if (Ksubs3_Noc16_RxData_rdy) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Register file and response holding registers. The response is only
  // loaded on acceptance, so it stays stable while the host stalls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_leds     <= 8'd0;
      r_abend    <= 8'd0;
      r_waypoint <= 8'd0;
      r_scratch  <= 32'd0;
      r_rx_lo    <= 64'd0;
      r_rx_cmd   <= 8'd0;
    end else if (w_accept) begin
      if (w_wr_leds)     r_leds     <= w_wdata[7:0];
      if (w_wr_abend)    r_abend    <= w_wdata[7:0];
      if (w_wr_waypoint) r_waypoint <= w_wdata[7:0];
      if (w_wr_scratch)  r_scratch  <= w_wdata;
      r_rx_lo  <= {w_addr, 24'd0, w_rsp_data};
      r_rx_cmd <= w_rsp_cmd;
    end
  end

`ifdef NOC16_RESP_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt_accept <= 16'd0;
      r_cnt_error  <= 16'd0;
    end else if (w_accept) begin
      if (r_cnt_accept != 16'hFFFF)             r_cnt_accept <= r_cnt_accept + 16'd1;
      if (w_is_err && r_cnt_error != 16'hFFFF)  r_cnt_error  <= r_cnt_error + 16'd1;
    end
  end
`else
  logic w_unused_err;
  assign w_unused_err = w_is_err;
`endif

  assign Ksubs3_Noc16_RxData_lo  = r_rx_lo;
  assign Ksubs3_Noc16_RxData_cmd = r_rx_cmd;
  assign ksubsGpioLeds           = r_leds;
  assign ksubsAbendSyndrome      = r_abend;
  assign ksubsManualWaypoint     = r_waypoint;

endmodule
`default_nettype wire

// File: tb/tb_noc16_reg_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_noc16_reg_responder
// Description : Directed self-checking bench for noc16_reg_responder.
//               Honours NOC16_RESP_STATS_EN for the STATS register check.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_noc16_reg_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] tx_lo = 64'd0;
  logic [7:0]  tx_cmd = 8'd0;
  logic        tx_valid = 1'b0;
  logic        tx_rdy;
  logic [63:0] rx_lo;
  logic [7:0]  rx_cmd;
  logic        rx_valid;
  logic        rx_rdy = 1'b0;
  logic [7:0]  switches = 8'd0;
  logic [7:0]  leds;
  logic [7:0]  abend;
  logic [7:0]  waypoint;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  noc16_reg_responder #(.SERIAL_NUMBER(32'd1236)) dut (
    .clk                       (clk),
    .reset                     (reset),
    .Ksubs3_Noc16_TxData_lo    (tx_lo),
    .Ksubs3_Noc16_TxData_cmd   (tx_cmd),
    .Ksubs3_Noc16_TxData_valid (tx_valid),
    .Ksubs3_Noc16_TxData_rdy   (tx_rdy),
    .Ksubs3_Noc16_RxData_lo    (rx_lo),
    .Ksubs3_Noc16_RxData_cmd   (rx_cmd),
    .Ksubs3_Noc16_RxData_valid (rx_valid),
    .Ksubs3_Noc16_RxData_rdy   (rx_rdy),
    .ksubsGpioSwitches         (switches),
    .ksubsGpioLeds             (leds),
    .ksubsAbendSyndrome        (abend),
    .ksubsManualWaypoint       (waypoint)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present one command, wait for acceptance and check the response beat
  // that appears one cycle later. The response is left pending.
  task automatic send(input string tag, input logic [7:0] op, input logic [7:0] addr,
                      input logic [31:0] data, input logic [7:0] exp_cmd,
                      input logic [31:0] exp_data, input bit chk_data);
    int waited = 0;
    while (!tx_rdy && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!tx_rdy) check({tag, "_rdy_timeout"}, 64'd0, 64'd1);
    tx_lo    = {addr, 24'd0, data};
    tx_cmd   = op;
    tx_valid = 1'b1;
    @(posedge clk); #1;
    tx_valid = 1'b0;
    check({tag, "_valid"}, {63'd0, rx_valid}, 64'd1);
    check({tag, "_cmd"}, {56'd0, rx_cmd}, {56'd0, exp_cmd});
    if (chk_data) check({tag, "_lo"}, rx_lo, {addr, 24'd0, exp_data});
    else          check({tag, "_addr"}, {56'd0, rx_lo[63:56]}, {56'd0, addr});
  endtask

  task automatic ack(input string tag);
    rx_rdy = 1'b1;
    @(posedge clk); #1;
    rx_rdy = 1'b0;
    check({tag, "_idle_rdy"}, {63'd0, tx_rdy}, 64'd1);
    check({tag, "_idle_valid"}, {63'd0, rx_valid}, 64'd0);
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_rx_valid", {63'd0, rx_valid}, 64'd0);
    check("rst_rx_lo", rx_lo, 64'd0);
    check("rst_rx_cmd", {56'd0, rx_cmd}, 64'd0);
    check("rst_leds", {56'd0, leds}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    check("rst_tx_rdy", {63'd0, tx_rdy}, 64'd1);

    // Serial number: 1236 = 0x4D4
    send("rd_serial", 8'h01, 8'h00, 32'h0, 8'h81, 32'h0000_04D4, 1'b1);
    check("rd_serial_full", rx_lo, 64'h0000_0000_0000_04D4);
    ack("rd_serial");

    // LED write takes only data[7:0], visible in the cycle the response appears
    send("wr_leds", 8'h02, 8'h02, 32'h0000_01A5, 8'h82, 32'h0, 1'b0);
    check("wr_leds_out", {56'd0, leds}, 64'hA5);
    ack("wr_leds");
    send("rd_leds", 8'h01, 8'h02, 32'h0, 8'h81, 32'h0000_00A5, 1'b1);
    ack("rd_leds");

    // Scratch write with the host stalling; a second command is offered
    // during the stall and must be ignored.
    send("wr_scr", 8'h02, 8'h05, 32'hDEAD_BEEF, 8'h82, 32'h0, 1'b0);
    tx_lo    = {8'h02, 24'd0, 32'h77};
    tx_cmd   = 8'h02;
    tx_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("stall_valid", {63'd0, rx_valid}, 64'd1);
      check("stall_cmd", {56'd0, rx_cmd}, 64'h82);
      check("stall_lo", {56'd0, rx_lo[63:56]}, 64'h05);
      check("stall_tx_rdy", {63'd0, tx_rdy}, 64'd0);
      check("stall_leds", {56'd0, leds}, 64'hA5);
    end
    tx_valid = 1'b0;
    ack("wr_scr");
    send("rd_scr", 8'h01, 8'h05, 32'h0, 8'h81, 32'hDEAD_BEEF, 1'b1);
    ack("rd_scr");

    // Error cases: no state change, address echoed, data zero
    send("bad_op", 8'h07, 8'h02, 32'h0000_0011, 8'hFF, 32'h0, 1'b1);
    ack("bad_op");
    send("wr_ro", 8'h02, 8'h00, 32'h1234_5678, 8'hFF, 32'h0, 1'b1);
    ack("wr_ro");
    send("rd_unmap", 8'h01, 8'h09, 32'h0, 8'hFF, 32'h0, 1'b1);
    ack("rd_unmap");
    check("err_leds_kept", {56'd0, leds}, 64'hA5);
    send("rd_serial2", 8'h01, 8'h00, 32'h0, 8'h81, 32'h0000_04D4, 1'b1);
    ack("rd_serial2");

    // Abend and waypoint registers
    send("wr_abend", 8'h02, 8'h03, 32'h0000_005A, 8'h82, 32'h0, 1'b0);
    check("abend_out", {56'd0, abend}, 64'h5A);
    ack("wr_abend");
    send("wr_wp", 8'h02, 8'h04, 32'hFFFF_FF33, 8'h82, 32'h0, 1'b0);
    check("wp_out", {56'd0, waypoint}, 64'h33);
    ack("wr_wp");
    send("rd_wp", 8'h01, 8'h04, 32'h0, 8'h81, 32'h0000_0033, 1'b1);
    ack("rd_wp");
    send("rd_abend", 8'h01, 8'h03, 32'h0, 8'h81, 32'h0000_005A, 1'b1);
    ack("rd_abend");

    // Switches through the synchroniser
    switches = 8'h3C;
    repeat (3) @(posedge clk);
    #1;
    send("rd_sw", 8'h01, 8'h01, 32'h0, 8'h81, 32'h0000_003C, 1'b1);
    ack("rd_sw");

    // Reset while a response is pending
    send("wr_leds2", 8'h02, 8'h02, 32'h0000_0066, 8'h82, 32'h0, 1'b0);
    check("leds2_out", {56'd0, leds}, 64'h66);
    #3;
    reset = 1'b1;
    #1;
    check("arst_rx_valid", {63'd0, rx_valid}, 64'd0);
    check("arst_leds", {56'd0, leds}, 64'd0);
    check("arst_abend", {56'd0, abend}, 64'd0);
    check("arst_wp", {56'd0, waypoint}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    check("arst_tx_rdy", {63'd0, tx_rdy}, 64'd1);
    check("arst_rx_cmd", {56'd0, rx_cmd}, 64'd0);

    // Served normally after reset; three commands including one error
    send("post_serial", 8'h01, 8'h00, 32'h0, 8'h81, 32'h0000_04D4, 1'b1);
    ack("post_serial");
    send("post_wr", 8'h02, 8'h02, 32'h0000_0011, 8'h82, 32'h0, 1'b0);
    check("post_leds", {56'd0, leds}, 64'h11);
    ack("post_wr");
    send("post_err", 8'h01, 8'h09, 32'h0, 8'hFF, 32'h0, 1'b1);
    ack("post_err");
`ifdef NOC16_RESP_STATS_EN
    send("rd_stats", 8'h01, 8'h06, 32'h0, 8'h81, 32'h0003_0001, 1'b1);
`else
    send("rd_stats", 8'h01, 8'h06, 32'h0, 8'hFF, 32'h0, 1'b1);
`endif
    ack("rd_stats");
    check("final_scratch_cleared_leds", {56'd0, leds}, 64'h11);
    send("rd_scr_clr", 8'h01, 8'h05, 32'h0, 8'h81, 32'h0, 1'b1);
    ack("rd_scr_clr");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/noc16_reg_responder.md
# noc16_reg_responder

Device-side responder for the Ksubs3 NOC16 service channel. Accepts single-beat read/write commands from the host on the TxData channel, executes them against a small register file (serial number, GPIO LEDs/switches, abend syndrome, manual waypoint, scratch) and returns one response beat per command on the RxData channel. Sits inside the device top level, between the NOC16 link and the GPIO/status outputs.

## Interface
Parameters:
- SERIAL_NUMBER, 32'd1236, value returned by register 0x00.

Ports:
- clk  in  1  system clock; one clock, all logic on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- Ksubs3_Noc16_TxData_lo  in  64  command payload: [63:56] address, [31:0] write data.
- Ksubs3_Noc16_TxData_cmd  in  8  command opcode.
- Ksubs3_Noc16_TxData_valid  in  1  command beat valid.
- Ksubs3_Noc16_TxData_rdy  out  1  responder can accept a command.
- Ksubs3_Noc16_RxData_lo  out  64  response payload: [63:56] echoed address, [31:0] read data.
- Ksubs3_Noc16_RxData_cmd  out  8  response code.
- Ksubs3_Noc16_RxData_valid  out  1  response beat valid.
- Ksubs3_Noc16_RxData_rdy  in  1  host accepts response.
- ksubsGpioSwitches  in  8  asynchronous switch inputs.
- ksubsGpioLeds  out  8  LED register.
- ksubsAbendSyndrome  out  8  abend syndrome register.
- ksubsManualWaypoint  out  8  manual waypoint register.

## Operation
- Opcodes: 0x01 READ, 0x02 WRITE. Responses: 0x81 READ_ACK, 0x82 WRITE_ACK, 0xFF ERROR.
- Register map (address = lo[63:56]): 0x00 SERIAL RO; 0x01 SWITCHES RO (synchronised, zero-extended); 0x02 LEDS RW[7:0]; 0x03 ABEND RW[7:0]; 0x04 WAYPOINT RW[7:0]; 0x05 SCRATCH RW[31:0]; 0x06 STATS (only with macro).
- Narrow registers: write takes data[7:0], upper bits ignored; read zero-extends to 32 bits. RxData_lo[55:32] always 0.
- ERROR for: unknown opcode, unmapped address, WRITE to RO register. Errored writes change no state. ERROR payload: address echoed, data 0.
- FSM: IDLE (TxData_rdy=1) -> on valid&rdy: execute, load response, go RESP. RESP (TxData_rdy=0, RxData_valid=1) -> on RxData_rdy: go IDLE. One command outstanding.
- Response payload/cmd held stable while RxData_valid=1 and RxData_rdy=0.
- Switches pass through a 2-flop synchroniser before being readable.
- Reset values: TxData_rdy 1 (after reset release), RxData_valid 0, RxData_lo 0, RxData_cmd 0, LEDs 0, abend 0, waypoint 0, scratch 0, stats 0.

## Timing
- Command accepted in cycle N -> register write visible on outputs and RxData_valid=1 in cycle N+1.
- RxData_rdy=1 in cycle M with valid -> back to IDLE, TxData_rdy=1 in M+1; minimum 2 cycles per transaction; no back-to-back acceptance.
- TxData_valid while TxData_rdy=0: ignored, not consumed; host must hold.
- READ of SWITCHES returns value sampled 2 cycles earlier (synchroniser latency).
- Reset asserted mid-transaction: RxData_valid drops immediately (async), FSM to IDLE, pending response discarded, registers cleared.

## Configuration
- NOC16_RESP_STATS_EN defined: register 0x06 STATS RO = {accepted-command count[15:0], error count[15:0]}, both 16-bit saturating, incremented at acceptance; READ of STATS returns counts before the current command is counted.
- Undefined: no counters; address 0x06 is unmapped -> ERROR.

## Structure
- Package noc16_pkg: opcode and response-code constants, register address constants, FSM state typedef.
- One sub-module: noc16_sync2 (8-bit two-flop synchroniser with async reset to 0) for the switches.

## Test plan
- Reset, READ 0x00 -> RxData_cmd 0x81, lo = 0x00000000_000004D4 with [63:56]=0x00, one cycle after acceptance.
- WRITE 0x02 data 0x1A5 -> 0x82, ksubsGpioLeds=0xA5 in N+1; READ 0x02 -> data 0x000000A5.
- WRITE 0x05 0xDEADBEEF with RxData_rdy held low 5 cycles -> response stable, TxData_rdy=0 throughout; READ 0x05 -> 0xDEADBEEF.
- Opcode 0x07, WRITE to 0x00, READ 0x09 -> each 0xFF, no state change.
- Switches=0x3C -> READ 0x01 ≥3 cycles later returns 0x3C.
- Reset pulse while RESP pending -> RxData_valid 0 same cycle, LEDs 0, next command served normally; with NOC16_RESP_STATS_EN, 3 commands incl. 1 error -> READ 0x06 returns 0x00030001.
